// File: rtl/cam_pkg.sv
// Shared types and width helpers for the ternary CAM lookup engines.
// Entries are held at the widest supported key width; narrower instances zero-fill the top.
package cam_pkg;

    localparam int CAM_KEY_MAX = 128;

    typedef enum logic [2:0] {
        OP_SEARCH = 3'd0,
        OP_WRITE  = 3'd1,
        OP_READ   = 3'd2,
        OP_INVAL  = 3'd3,
        OP_FLUSH  = 3'd4
    } tcam_op_e;

    typedef struct packed {
        logic [CAM_KEY_MAX-1:0] key;
        logic [CAM_KEY_MAX-1:0] mask;
        logic                   vld;
    } tcam_entry_t;

    function automatic int cam_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cam_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Match-line encoder: lowest set index, any-hit flag and population count.
module tcam_prio_enc
    import cam_pkg::*;
#(
    parameter  int WIDTH = 64,
    localparam int IDX_W = cam_addr_w(WIDTH),
    localparam int CNT_W = cam_cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] match,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [CNT_W-1:0] cnt
);

    // Scanning downwards lets the lowest set bit be the last (winning) assignment.
    always_comb begin
        idx = '0;
        cnt = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(match[i]);
        end
    end

    assign any = |match;

endmodule

// File: rtl/tcam_pipe.sv
// Two-stage pipelined ternary CAM with stored masks, read-back, invalidate and flush.
// S1 captures the match line / read data at accept; S2 encodes and holds the response.
module tcam_pipe
    import cam_pkg::*;
#(
    parameter  int KEY_WIDTH = 32,
    parameter  int KEY_DEPTH = 64,
    localparam int ADDR_W    = cam_addr_w(KEY_DEPTH),
    localparam int CNT_W     = cam_cnt_w(KEY_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  tcam_op_e             req_op,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [KEY_WIDTH-1:0] req_key,
    input  logic [KEY_WIDTH-1:0] req_mask,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output tcam_op_e             resp_op,
    output logic                 resp_hit,
    output logic [ADDR_W-1:0]    resp_idx,
    output logic [CNT_W-1:0]     resp_cnt,
    output logic [KEY_WIDTH-1:0] resp_key,
    output logic [KEY_WIDTH-1:0] resp_mask,
    output logic                 resp_err
);

    if (KEY_WIDTH > CAM_KEY_MAX || KEY_WIDTH < 1 || KEY_DEPTH < 2) begin : g_param_check
        $error("tcam_pipe: unsupported KEY_WIDTH/KEY_DEPTH");
    end

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic resp_valid_q, resp_valid_d;
    logic s1_adv, s2_adv, acc;

    assign s2_adv    = ~resp_valid_q | resp_ready;
    assign s1_adv    = ~s1_valid_q | s2_adv;
    assign req_ready = s1_adv;
    assign acc       = req_valid & s1_adv;

    // Request decode
    logic                   addr_ok, addr_err;
    logic [CAM_KEY_MAX-1:0] key_ext, wr_key_ext, wr_mask_ext;

    assign addr_ok     = (int'(req_addr) < KEY_DEPTH);
    assign addr_err    = ~addr_ok & ((req_op == OP_WRITE) | (req_op == OP_READ) | (req_op == OP_INVAL));
    assign key_ext     = CAM_KEY_MAX'(req_key);
    assign wr_key_ext  = CAM_KEY_MAX'(req_key & req_mask);
    assign wr_mask_ext = CAM_KEY_MAX'(req_mask);

    // Entry table
    logic [KEY_DEPTH-1:0] match_line;
    logic [KEY_DEPTH-1:0] ent_vld_all;
    logic [KEY_WIDTH-1:0] ent_key_all  [KEY_DEPTH];
    logic [KEY_WIDTH-1:0] ent_mask_all [KEY_DEPTH];

    for (genvar gi = 0; gi < KEY_DEPTH; gi++) begin : g_ent
        tcam_entry_t ent_q, ent_d;
        logic        sel;

        assign sel = (req_addr == ADDR_W'(gi));

        // Out-of-range addresses never match sel, so they leave the table untouched.
        always_comb begin
            ent_d = ent_q;
            if (acc) begin
                if (req_op == OP_FLUSH) begin
                    ent_d.vld = 1'b0;
                end else if (sel && req_op == OP_INVAL) begin
                    ent_d.vld = 1'b0;
                end else if (sel && req_op == OP_WRITE) begin
                    ent_d.key  = wr_key_ext;
                    ent_d.mask = wr_mask_ext;
                    ent_d.vld  = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ent_q.vld <= 1'b0;
            end else begin
                ent_q <= ent_d;
            end
        end

        assign match_line[gi]   = ent_q.vld & ~|((ent_q.key ^ key_ext) & ent_q.mask);
        assign ent_vld_all[gi]  = ent_q.vld;
        assign ent_key_all[gi]  = ent_q.key[KEY_WIDTH-1:0];
        assign ent_mask_all[gi] = ent_q.mask[KEY_WIDTH-1:0];
    end

    // Stage 1
    tcam_op_e             s1_op_q, s1_op_d;
    logic                 s1_err_q, s1_err_d;
    logic [KEY_DEPTH-1:0] s1_match_q, s1_match_d;
    logic                 s1_rd_vld_q, s1_rd_vld_d;
    logic [KEY_WIDTH-1:0] s1_rd_key_q, s1_rd_key_d;
    logic [KEY_WIDTH-1:0] s1_rd_mask_q, s1_rd_mask_d;

    // A stalled S1 keeps its captured match line; no accept can change the table meanwhile.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_err_d     = s1_err_q;
        s1_match_d   = s1_match_q;
        s1_rd_vld_d  = s1_rd_vld_q;
        s1_rd_key_d  = s1_rd_key_q;
        s1_rd_mask_d = s1_rd_mask_q;
        if (s1_adv) begin
            s1_valid_d   = acc;
            s1_op_d      = acc ? req_op : OP_SEARCH;
            s1_err_d     = acc & addr_err;
            s1_match_d   = (acc && req_op == OP_SEARCH) ? match_line : '0;
            s1_rd_vld_d  = acc && req_op == OP_READ && addr_ok && ent_vld_all[req_addr];
            s1_rd_key_d  = s1_rd_vld_d ? ent_key_all[req_addr] : '0;
            s1_rd_mask_d = s1_rd_vld_d ? ent_mask_all[req_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_SEARCH;
            s1_err_q     <= 1'b0;
            s1_match_q   <= '0;
            s1_rd_vld_q  <= 1'b0;
            s1_rd_key_q  <= '0;
            s1_rd_mask_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_err_q     <= s1_err_d;
            s1_match_q   <= s1_match_d;
            s1_rd_vld_q  <= s1_rd_vld_d;
            s1_rd_key_q  <= s1_rd_key_d;
            s1_rd_mask_q <= s1_rd_mask_d;
        end
    end

    // Stage 2
    logic [ADDR_W-1:0] enc_idx;
    logic              enc_any;
    logic [CNT_W-1:0]  enc_cnt;

    tcam_prio_enc #(
        .WIDTH (KEY_DEPTH)
    ) u_prio (
        .match (s1_match_q),
        .idx   (enc_idx),
        .any   (enc_any),
        .cnt   (enc_cnt)
    );

    tcam_op_e             resp_op_q, resp_op_d;
    logic                 resp_hit_q, resp_hit_d;
    logic [ADDR_W-1:0]    resp_idx_q, resp_idx_d;
    logic [CNT_W-1:0]     resp_cnt_q, resp_cnt_d;
    logic [KEY_WIDTH-1:0] resp_key_q, resp_key_d;
    logic [KEY_WIDTH-1:0] resp_mask_q, resp_mask_d;
    logic                 resp_err_q, resp_err_d;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_op_d    = resp_op_q;
        resp_hit_d   = resp_hit_q;
        resp_idx_d   = resp_idx_q;
        resp_cnt_d   = resp_cnt_q;
        resp_key_d   = resp_key_q;
        resp_mask_d  = resp_mask_q;
        resp_err_d   = resp_err_q;
        if (s2_adv) begin
            resp_valid_d = s1_valid_q;
            resp_op_d    = s1_op_q;
            resp_hit_d   = 1'b0;
            resp_idx_d   = '0;
            resp_cnt_d   = '0;
            resp_key_d   = '0;
            resp_mask_d  = '0;
            resp_err_d   = s1_valid_q & s1_err_q;
            if (s1_valid_q) begin
                case (s1_op_q)
                    OP_SEARCH: begin
                        resp_hit_d = enc_any;
                        resp_idx_d = enc_idx;
                        resp_cnt_d = enc_cnt;
                    end
                    OP_READ: begin
                        resp_hit_d  = s1_rd_vld_q;
                        resp_key_d  = s1_rd_key_q;
                        resp_mask_d = s1_rd_mask_q;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_op_q    <= OP_SEARCH;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= '0;
            resp_cnt_q   <= '0;
            resp_key_q   <= '0;
            resp_mask_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_op_q    <= resp_op_d;
            resp_hit_q   <= resp_hit_d;
            resp_idx_q   <= resp_idx_d;
            resp_cnt_q   <= resp_cnt_d;
            resp_key_q   <= resp_key_d;
            resp_mask_q  <= resp_mask_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_op    = resp_op_q;
    assign resp_hit   = resp_hit_q;
    assign resp_idx   = resp_idx_q;
    assign resp_cnt   = resp_cnt_q;
    assign resp_key   = resp_key_q;
    assign resp_mask  = resp_mask_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_tcam_pipe.sv
// Directed bench for tcam_pipe: 10-entry, 32-bit table, hand-computed responses.
module tb_tcam_pipe;
    import cam_pkg::*;

    localparam int KW = 32;
    localparam int KD = 10;
    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    tcam_op_e      req_op;
    logic [AW-1:0] req_addr;
    logic [KW-1:0] req_key;
    logic [KW-1:0] req_mask;
    logic          resp_valid;
    logic          resp_ready;
    tcam_op_e      resp_op;
    logic          resp_hit;
    logic [AW-1:0] resp_idx;
    logic [CW-1:0] resp_cnt;
    logic [KW-1:0] resp_key;
    logic [KW-1:0] resp_mask;
    logic          resp_err;

    always #5 clk = ~clk;

    tcam_pipe #(
        .KEY_WIDTH (KW),
        .KEY_DEPTH (KD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_key    (req_key),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_op    (resp_op),
        .resp_hit   (resp_hit),
        .resp_idx   (resp_idx),
        .resp_cnt   (resp_cnt),
        .resp_key   (resp_key),
        .resp_mask  (resp_mask),
        .resp_err   (resp_err)
    );

    typedef struct {
        tcam_op_e      op;
        logic          hit;
        logic [AW-1:0] idx;
        logic [CW-1:0] cnt;
        logic [KW-1:0] key;
        logic [KW-1:0] mask;
        logic          err;
        int            cyc;
        bit            lat;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    int          n_vec   = 0;
    int          n_miss  = 0;
    int          cyc     = 0;
    int          rr_mode = 0;
    bit          stall   = 0;
    logic [63:0] prev_meta;
    logic [63:0] prev_data;
    logic [31:0] rkey;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t mk(input int hit, input int idx, input int cnt,
                                input logic [KW-1:0] key, input logic [KW-1:0] mask,
                                input int err, input bit lat);
        rsp_t r;
        r.op   = OP_SEARCH;
        r.hit  = 1'(hit);
        r.idx  = AW'(idx);
        r.cnt  = CW'(cnt);
        r.key  = key;
        r.mask = mask;
        r.err  = 1'(err);
        r.cyc  = 0;
        r.lat  = lat;
        return r;
    endfunction

    // Response monitor: drives resp_ready, collects responses, checks stall/ready rules.
    always begin
        @(negedge clk);
        case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom_range(0, 1));
            default: resp_ready = 1'b0;
        endcase
        #1;
        if (rst) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("stall_valid", 64'(resp_valid), 64'(1));
                chk("stall_meta", 64'({resp_op, resp_hit, resp_idx, resp_cnt, resp_err}), prev_meta);
                chk("stall_data", {resp_key, resp_mask}, prev_data);
            end
            if (resp_ready || !resp_valid) begin
                chk("req_ready_free", 64'(req_ready), 64'(1));
            end
            if (resp_valid && resp_ready) begin
                rsp_t g;
                g.op   = resp_op;
                g.hit  = resp_hit;
                g.idx  = resp_idx;
                g.cnt  = resp_cnt;
                g.key  = resp_key;
                g.mask = resp_mask;
                g.err  = resp_err;
                g.cyc  = cyc;
                g.lat  = 0;
                got_q.push_back(g);
                $display("resp #%0d op=%0d hit=%0d idx=%0d cnt=%0d key=%h mask=%h err=%0d",
                         got_q.size(), resp_op, resp_hit, resp_idx, resp_cnt, resp_key, resp_mask, resp_err);
            end
            stall     = resp_valid && !resp_ready;
            prev_meta = 64'({resp_op, resp_hit, resp_idx, resp_cnt, resp_err});
            prev_data = {resp_key, resp_mask};
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic issue(input tcam_op_e op, input int addr, input logic [KW-1:0] key,
                         input logic [KW-1:0] mask, input rsp_t e);
        int   w = 0;
        rsp_t x = e;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = AW'(addr);
        req_key   = key;
        req_mask  = mask;
        #2;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            #2;
            w++;
        end
        chk("req_accept", 64'(req_ready), 64'(1));
        x.op  = op;
        x.cyc = cyc;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic srch(input logic [KW-1:0] key, input int hit, input int idx, input int cnt, input bit lat);
        issue(OP_SEARCH, 0, key, '0, mk(hit, idx, cnt, '0, '0, 0, lat));
    endtask

    task automatic wr(input int addr, input logic [KW-1:0] key, input logic [KW-1:0] mask, input int err);
        issue(OP_WRITE, addr, key, mask, mk(0, 0, 0, '0, '0, err, 0));
    endtask

    task automatic rd(input int addr, input int hit, input logic [KW-1:0] key, input logic [KW-1:0] mask, input int err);
        issue(OP_READ, addr, '0, '0, mk(hit, 0, 0, key, mask, err, 0));
    endtask

    task automatic inv(input int addr, input int err);
        issue(OP_INVAL, addr, '0, '0, mk(0, 0, 0, '0, '0, err, 0));
    endtask

    task automatic fl();
        issue(OP_FLUSH, 0, '0, '0, mk(0, 0, 0, '0, '0, 0, 0));
    endtask

    task automatic drain(input string name);
        int    w = 0;
        int    k = 0;
        rsp_t  e;
        rsp_t  g;
        string tag;
        while (got_q.size() < exp_q.size() && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        chk({name, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e   = exp_q.pop_front();
            g   = got_q.pop_front();
            k++;
            tag = $sformatf("%s#%0d", name, k);
            chk({tag, ".op"},   64'(g.op),   64'(e.op));
            chk({tag, ".hit"},  64'(g.hit),  64'(e.hit));
            chk({tag, ".idx"},  64'(g.idx),  64'(e.idx));
            chk({tag, ".cnt"},  64'(g.cnt),  64'(e.cnt));
            chk({tag, ".key"},  64'(g.key),  64'(e.key));
            chk({tag, ".mask"}, 64'(g.mask), 64'(e.mask));
            chk({tag, ".err"},  64'(g.err),  64'(e.err));
            if (e.lat) begin
                chk({tag, ".lat"}, 64'(g.cyc), 64'(e.cyc + 2));
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required below 400000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = OP_SEARCH;
        req_addr   = '0;
        req_key    = '0;
        req_mask   = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset.resp_valid", 64'(resp_valid), 64'(0));
        chk("reset.req_ready", 64'(req_ready), 64'(1));
        chk("reset.meta", 64'({resp_op, resp_hit, resp_idx, resp_cnt, resp_err}), 64'(0));
        chk("reset.data", {resp_key, resp_mask}, 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Empty table
        srch(32'h0, 0, 0, 0, 1);
        rd(5, 0, 32'h0, 32'h0, 0);
        drain("empty");

        // Masked and exact entries, lowest index wins
        wr(3, 32'h12340000, 32'hFFFF0000, 0);
        wr(7, 32'h12345678, 32'hFFFFFFFF, 0);
        srch(32'h12345678, 1, 3, 2, 1);
        inv(3, 0);
        srch(32'h12345678, 1, 7, 1, 0);
        rd(3, 0, 32'h0, 32'h0, 0);
        rd(7, 1, 32'h12345678, 32'hFFFFFFFF, 0);
        drain("prio");

        // All-don't-care entry at the top index, out-of-range addresses
        wr(KD - 1, 32'hDEADBEEF, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            rkey = $urandom;
            if (rkey == 32'h12345678) rkey = ~rkey;
            srch(rkey, 1, 9, 1, 0);
        end
        rd(KD - 1, 1, 32'h0, 32'h0, 0);
        wr(KD, 32'h12345678, 32'hFFFFFFFF, 1);
        srch(32'h12345678, 1, 7, 2, 0);
        rd(KD, 0, 32'h0, 32'h0, 1);
        inv(KD, 1);
        srch(32'h12345678, 1, 7, 2, 0);
        drain("bound");

        // Back-to-back mixed stream with random backpressure
        rr_mode = 1;
        wr(0, 32'h000000AA, 32'h000000FF, 0);
        wr(1, 32'h0000AA00, 32'h0000FF00, 0);
        srch(32'h0000AAAA, 1, 0, 3, 0);
        rd(1, 1, 32'h0000AA00, 32'h0000FF00, 0);
        srch(32'h000000AA, 1, 0, 2, 0);
        inv(0, 0);
        srch(32'h0000AAAA, 1, 1, 2, 0);
        wr(2, 32'hFFFFFFFF, 32'hF0000000, 0);
        srch(32'hF0000000, 1, 2, 2, 0);
        srch(32'h12345678, 1, 7, 2, 0);
        rd(2, 1, 32'hF0000000, 32'hF0000000, 0);
        wr(12, 32'h1, 32'h1, 1);
        rd(0, 0, 32'h0, 32'h0, 0);
        inv(9, 0);
        srch(32'h00000000, 0, 0, 0, 0);
        wr(4, 32'h0, 32'h0, 0);
        srch(32'h00000000, 1, 4, 1, 0);
        srch(32'hFFFFAAFF, 1, 1, 3, 0);
        rd(15, 0, 32'h0, 32'h0, 1);
        srch(32'h12345678, 1, 4, 2, 0);
        drain("stream");
        rr_mode = 0;

        // Fill every entry, then flush and search immediately
        for (int i = 0; i < KD; i++) begin
            wr(i, 32'(i), 32'hFFFFFFFF, 0);
        end
        srch(32'h3, 1, 3, 1, 0);
        rd(KD - 1, 1, 32'h9, 32'hFFFFFFFF, 0);
        fl();
        srch(32'h3, 0, 0, 0, 0);
        rd(3, 0, 32'h0, 32'h0, 0);
        drain("flush");

        // Reset with two operations in flight
        wr(5, 32'hAAAA5555, 32'hFFFFFFFF, 0);
        drain("prefill");
        rr_mode = 2;
        srch(32'hAAAA5555, 1, 5, 1, 0);
        srch(32'hAAAA5555, 1, 5, 1, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        rr_mode = 0;
        repeat (6) @(negedge clk);
        chk("rst_inflight.resp_count", 64'(got_q.size()), 64'(0));
        chk("rst_inflight.resp_valid", 64'(resp_valid), 64'(0));
        exp_q.delete();
        got_q.delete();
        rd(5, 0, 32'h0, 32'h0, 0);
        srch(32'hAAAA5555, 0, 0, 0, 0);
        drain("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tcam_pipe.md
# tcam_pipe

Pipelined, parametrised ternary CAM with per-entry stored masks, a valid/ready request/response handshake, and in-order responses for every operation. It is the next-generation lookup engine in the CAM subsystem. It sits between the key-generation front end and the action table. It adds the following over the single-cycle TCAM:
- stored don't-care bits;
- lowest-index hit plus hit count;
- entry read-back, invalidate and flush-all operations;
- full backpressure.

## Interface
Parameters:
- KEY_WIDTH, 32, key and mask width in bits.
- KEY_DEPTH, 64, number of entries; any value ≥2, not necessarily a power of two.
- ADDR_W, $clog2(KEY_DEPTH), entry index width; derived, not overridden.
- CNT_W, $clog2(KEY_DEPTH+1), hit-count width; derived.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  3  operation, tcam_op_e: SEARCH, WRITE, READ, INVAL, FLUSH.
- req_addr  in  ADDR_W  entry index for WRITE/READ/INVAL.
- req_key  in  KEY_WIDTH  search key, or data for WRITE.
- req_mask  in  KEY_WIDTH  WRITE only; 1 = bit compared, 0 = don't care.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_op  out  3  echo of the op.
- resp_hit  out  1  SEARCH: at least one match. READ: the entry was valid.
- resp_idx  out  ADDR_W  lowest matching index; 0 on a miss.
- resp_cnt  out  CNT_W  number of matching entries.
- resp_key, resp_mask  out  KEY_WIDTH each  READ: stored data and mask; 0 for other ops.
- resp_err  out  1  req_addr ≥ KEY_DEPTH on WRITE, READ or INVAL.

## Operation
- Per-entry state: key, mask and valid bit. Reset clears all valid bits. Key and mask contents after reset are don't-care, but READ of an invalid entry must return key=0 and mask=0.
- Match rule for entry i: valid[i] & ~|((key[i] ^ req_key) & mask[i]). A stored mask of all zeros matches every key.
- WRITE:
  - Stores key & mask, so unmasked bits are stored as 0, and sets valid. The table updates on the accept edge.
  - A WRITE with an out-of-range address changes nothing and returns err=1.
- INVAL: clears valid[addr] on the accept edge.
- FLUSH: clears every valid bit on the accept edge.
- READ: samples the entry on the accept edge, i.e. it sees table state before any write accepted in that same edge. Only one request can be accepted per cycle, so there is no same-edge conflict.
- SEARCH: compares against the table as it stands after all previously accepted operations. A WRITE accepted at cycle N is visible to a SEARCH accepted at cycle N+1.
- Every accepted op produces exactly one response. Responses come out in acceptance order.
- For WRITE, INVAL and FLUSH the response is an acknowledgement: hit=0, idx=0, cnt=0, plus err where applicable.

## Timing
Two-stage pipeline:
- S1 registers the op, the KEY_DEPTH-bit match line and the read data.
- S2 registers the encoded response.
- resp_valid rises exactly 2 cycles after accept when resp_ready stays high.
- Sustained throughput is 1 op/cycle.

Handshake:
- Stage advance: s2_adv = ~s2_valid | resp_ready; s1_adv = ~s1_valid | s2_adv; req_ready = s1_adv.
- req_ready is combinational from resp_ready and contains no path from req_valid.
- resp_* payload holds stable while resp_valid & ~resp_ready.

Table update and stalls:
- Table updates occur only on accept.
- A stalled SEARCH in S1 keeps its already-computed match line. It is not re-evaluated, because no new op can be accepted while S1 is stalled.

Reset:
- Outputs after reset: resp_valid=0, req_ready=1, all resp_* payload 0.
- Reset mid-operation discards in-flight ops without responses and clears the table.

## Structure
- Shared package cam_pkg holds:
  - tcam_op_e;
  - a tcam_entry_t struct {key, mask, vld};
  - the width helper functions.
- Sub-module tcam_prio_enc: combinational, parameter WIDTH. Input is the match line; outputs are lowest set index, any, and popcount. It is instantiated in S2.
- Target: about 250 lines of RTL.

## Test plan
- Reset, then SEARCH key 0x0 → resp 2 cycles later with hit=0, idx=0, cnt=0. READ addr 5 → hit=0, key=0, mask=0.
- WRITE 3 (key 0x12340000, mask 0xFFFF0000), then WRITE 7 (key 0x12345678, mask 0xFFFFFFFF), back-to-back with SEARCH 0x12345678 → hit=1, idx=3, cnt=2. After INVAL 3 the same SEARCH gives idx=7, cnt=1.
- WRITE with mask 0 at addr KEY_DEPTH-1, SEARCH with random keys → that index always hits. WRITE to addr KEY_DEPTH (when KEY_DEPTH is not a power of two) → err=1 and the table is unchanged.
- Back-to-back stream of 20 mixed ops with resp_ready toggled randomly → responses in order, none dropped or duplicated, payload stable during stalls, req_ready low only while the pipeline is full.
- Fill all entries, FLUSH, SEARCH in the next cycle → hit=0, cnt=0.
- Assert rst with 2 ops in flight → no responses emerge; the table reads invalid afterwards.
